// File: rtl/spi_link_pkg.sv
// spi_link_pkg: link geometry and FSM state types shared by the SPI pixel link sender and receiver
package spi_link_pkg;
    localparam int LINK_DATA_WIDTH = 16;
    localparam int LINK_LINES = 6;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_CS} rx_state_t;
    typedef enum logic {EMPTY, DRAIN} tx_state_t;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser with rise/fall detection on the synchronised value
module sync_edge_det #(
    parameter int W = 1,
    parameter int STAGES = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);
    logic [STAGES-1:0][W-1:0] sr;
    logic [W-1:0] prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sr <= {sr[STAGES-2:0], d};
            prev <= sr[STAGES-1];
        end
    end
    assign q = sr[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/spi_recv_con.sv
// spi_recv_con: deserialises one LINES x DATA_WIDTH frame per chip select and replays it as a pixel stream
module spi_recv_con import spi_link_pkg::*; #(
    parameter int DATA_WIDTH = LINK_DATA_WIDTH,
    parameter int LINES = LINK_LINES,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [LINES-1:0]            chip_data_in,
    input  logic                        chip_clk_in,
    input  logic                        chip_sel_in,
    output logic [LINES*DATA_WIDTH-1:0] data_out,
    output logic                        data_valid_out,
    output logic [DATA_WIDTH-1:0]       pixel_out,
    output logic                        pixel_valid_out,
    input  logic                        pixel_ready_in,
    output logic                        overflow_out,
    output logic                        frame_err_out
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int IW = $clog2(LINES > 1 ? LINES : 2);

    logic cs_s, cs_rise, cs_fall, dclk_rise;
    logic [LINES-1:0] data_s;
    logic unused_dclk_q, unused_dclk_fall;
    logic [LINES-1:0] unused_data_rise, unused_data_fall;

    sync_edge_det #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_dclk (
        .clk(clk_in), .rst_n(rst_in), .d(chip_clk_in),
        .q(unused_dclk_q), .rise(dclk_rise), .fall(unused_dclk_fall)
    );
    sync_edge_det #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk_in), .rst_n(rst_in), .d(chip_sel_in),
        .q(cs_s), .rise(cs_rise), .fall(cs_fall)
    );
    sync_edge_det #(.W(LINES), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_data (
        .clk(clk_in), .rst_n(rst_in), .d(chip_data_in),
        .q(data_s), .rise(unused_data_rise), .fall(unused_data_fall)
    );

    rx_state_t rx_state, rx_next;
    logic [CW-1:0] bit_cnt;
    logic [LINES-1:0][DATA_WIDTH-1:0] shreg;
    logic last_bit, frame_err;

    // the final dclk edge wins over a coincident cs rise
    assign last_bit = dclk_rise && bit_cnt == CW'(DATA_WIDTH - 1);
    assign frame_err = rx_state == SHIFT && cs_rise && !last_bit;

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:    rx_next = cs_fall ? SHIFT : IDLE;
            SHIFT:   rx_next = last_bit ? DONE : cs_rise ? IDLE : SHIFT;
            default: rx_next = cs_s ? IDLE : WAIT_CS;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) rx_state <= IDLE;
        else rx_state <= rx_next;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bit_cnt <= '0;
            shreg <= '0;
            data_out <= '0;
            data_valid_out <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            data_valid_out <= rx_state == DONE;
            frame_err_out <= frame_err;
            if (rx_state == IDLE && cs_fall) begin
                bit_cnt <= '0;
                shreg <= '0;
            end else if (rx_state == SHIFT && dclk_rise) begin
                bit_cnt <= bit_cnt + 1'b1;
                for (int i = 0; i < LINES; i++) shreg[i] <= {shreg[i][DATA_WIDTH-2:0], data_s[i]};
            end
            if (rx_state == DONE) data_out <= shreg;
        end
    end

    tx_state_t tx_state, tx_next;
    logic [LINES-1:0][DATA_WIDTH-1:0] frame_buf;
    logic [IW-1:0] idx;
    logic take;

    assign pixel_valid_out = tx_state == DRAIN;
    assign take = pixel_valid_out && pixel_ready_in;
    assign pixel_out = pixel_valid_out ? frame_buf[idx] : '0;

    always_comb tx_next = tx_state == EMPTY ? (data_valid_out ? DRAIN : EMPTY) : (take && idx == '0 ? EMPTY : DRAIN);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) tx_state <= EMPTY;
        else tx_state <= tx_next;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            frame_buf <= '0;
            idx <= '0;
            overflow_out <= 1'b0;
        end else begin
            overflow_out <= data_valid_out && tx_state == DRAIN;
            if (tx_state == EMPTY && data_valid_out) begin
                frame_buf <= data_out;
                idx <= IW'(LINES - 1);
            end else if (take) begin
                idx <= idx - 1'b1;
            end
        end
    end
endmodule

// File: doc/spi_recv_con.md
Name: spi_recv_con

Overview:
- Receiving end of the 6-line parallel SPI pixel link driven by spi_send_con on the controller FPGA.
- Samples dclk/cs/data lines from the other board with clk_in, deserialises one LINES x DATA_WIDTH frame per chip-select assertion, and presents the whole frame.
- Also replays the frame as a one-pixel-per-beat valid/ready stream into the depth-map pipeline.

Parameters:
- DATA_WIDTH, 16, bits per line per frame (one pixel).
- LINES, 6, number of parallel data lines (pixels per frame).
- SYNC_STAGES, 2, flip-flop synchroniser depth on all chip_* inputs (min 2).

Ports:
- clk_in  input  1  system clock (100 MHz); must be >= 4x dclk frequency.
- rst_in  input  1  asynchronous, active-low reset.
- chip_data_in  input  LINES  serial data lines, bit i carries pixel i, MSB first.
- chip_clk_in  input  1  SPI data clock from sender; data sampled on its rising edge.
- chip_sel_in  input  1  chip select, active low.
- data_out  output  LINES*DATA_WIDTH  last complete frame, line i in slice [i*DATA_WIDTH +: DATA_WIDTH].
- data_valid_out  output  1  one-cycle pulse when data_out updates.
- pixel_out  output  DATA_WIDTH  streamed pixel.
- pixel_valid_out  output  1  stream valid.
- pixel_ready_in  input  1  stream ready from consumer.
- overflow_out  output  1  one-cycle pulse when a completed frame is dropped.
- frame_err_out  output  1  one-cycle pulse when cs rises mid-frame.

Behaviour:
- Reset (rst_in low, async): all outputs 0, synchronisers cleared to cs=1 and dclk=0, both FSMs idle.
- Input path:
  - chip_* pass through SYNC_STAGES flops.
  - Rising dclk edge = synced dclk 1 while previous synced value 0.
  - cs_fall and cs_rise are derived from synced cs the same way.
  - Data uses the same synchroniser depth, so it is aligned with the edge.
- Receive FSM:
  - IDLE: wait for cs_fall, then clear bit_cnt and shift regs, go to SHIFT.
  - SHIFT: on each dclk rise with cs low, shift each line's bit into LSB of its shift reg (MSB-first overall) and increment bit_cnt.
    - When bit_cnt reaches DATA_WIDTH on a rise: go to DONE.
    - cs_rise before DATA_WIDTH bits: pulse frame_err_out, discard, go to IDLE.
  - DONE: load data_out, pulse data_valid_out the next cycle, go to WAIT_CS.
  - WAIT_CS: ignore dclk edges until cs_rise, then go to IDLE.
  - cs_fall in any state other than IDLE is ignored.
  - cs_rise on the same cycle as the final dclk rise: the frame is complete (the edge is counted first), no error.
- Stream FSM (unloader):
  - EMPTY: on data_valid_out, copy frame to the unload buffer, set idx=LINES-1, go to DRAIN.
  - DRAIN: pixel_out = buffer[idx], pixel_valid_out=1.
    - On valid&ready: idx-1.
    - After idx 0 is accepted: go to EMPTY next cycle (valid low).
  - Order is line LINES-1 first (oldest pixel from sender), line 0 last.
  - pixel_out is held stable while valid & !ready.
- Overflow:
  - If data_valid_out fires while in DRAIN, the new frame is dropped from the stream and overflow_out pulses.
  - data_out still updates.
  - A frame completing on the cycle the last pixel is accepted counts as overflow (no same-cycle handoff).
- Latency:
  - Final dclk pad edge to data_valid_out = SYNC_STAGES+2 cycles.
  - data_valid_out to first pixel_valid_out = 1 cycle.
- Reset mid-frame or mid-drain: immediate return to reset values; a partial frame is lost.

Decomposition:
- Shared package spi_link_pkg:
  - LINES and DATA_WIDTH defaults, shared with spi_send_con.
  - rx_state_t {IDLE, SHIFT, DONE, WAIT_CS}.
  - tx_state_t {EMPTY, DRAIN}.
- One sub-module: sync_edge_det, a parameterised synchroniser plus rise/fall detector, instantiated for dclk and cs.
  - Data lines use its synchroniser-only path.

Test Plan:
- Single frame, dclk = clk_in/6, lines 0..5 = 16'hA5A5, 16'h0001, 16'h8000, 16'hFFFF, 16'h1234, 16'hBEEF, ready held 1:
  - data_valid_out pulses once with exact slices.
  - Stream emits BEEF, 1234, FFFF, 8000, 0001, A5A5 on 6 consecutive cycles.
- Backpressure: ready toggled 1,0,0,1 pattern:
  - pixel_out stable while stalled.
  - All 6 pixels in order, none duplicated.
- cs raised after 9 bits:
  - frame_err_out pulses once, no data_valid_out.
  - Next full frame 16'h00FF on all lines is received correctly.
- Second frame completes while ready=0 and first frame still draining:
  - overflow_out pulses, data_out shows frame 2.
  - Stream continues with frame 1 only.
- Extra dclk pulses after the 16th bit before cs rises:
  - Ignored, data_out unchanged.
  - Next frame aligned correctly.
- rst_in low for 1 cycle mid-SHIFT (bit 7):
  - All outputs 0 immediately, no pulses.
  - Subsequent full frame received correctly.
